// File: rtl/exec_seq_pkg.sv
// ---------------------------------------------------------------------------
// exec_seq_pkg : state encoding and default widths for the execution sequencer
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package exec_seq_pkg;

  typedef enum logic [1:0] {
    ST_HALT  = 2'b00,
    ST_FETCH = 2'b01,
    ST_WAIT  = 2'b10,
    ST_EXEC  = 2'b11
  } state_e;

  localparam int DEF_ADDR_W = 5;
  localparam int DEF_INST_W = 6;
  localparam int DEF_CNT_W  = 16;

endpackage

`default_nettype wire

// File: rtl/retire_counter.sv
// ---------------------------------------------------------------------------
// retire_counter : saturating instruction-retire counter with enable
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module retire_counter
  import exec_seq_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  output logic [CNT_W-1:0] count_o
);

  logic [CNT_W-1:0] count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (en_i && (count_q != '1)) begin
      count_q <= count_q + CNT_W'(1);
    end
  end

  assign count_o = count_q;

endmodule

`default_nettype wire

// File: rtl/exec_seq.sv
// ---------------------------------------------------------------------------
// exec_seq : run/step/halt sequencer owning the PC, IR and commit strobe
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module exec_seq
  import exec_seq_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int INST_W  = DEF_INST_W,
  parameter int CNT_W   = DEF_CNT_W,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  input  logic              step,
  input  logic              halt_req,
  input  logic              bp_en,
  input  logic [ADDR_W-1:0] bp_addr,
  input  logic              ld_pc,
  input  logic [ADDR_W-1:0] ld_addr,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [INST_W-1:0] mem_data,
  output logic [INST_W-1:0] ir,
  output logic              commit,
  output logic              halted,
  output logic              bp_hit,
  output logic [CNT_W-1:0]  retired,
  output logic [1:0]        state
);

  state_e            state_q;
  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] pc_inc;
  logic [INST_W-1:0] ir_q;
  logic              bp_hit_q;
  logic              halt_pend_q;
  logic              single_q;

  assign pc_inc = pc_q + ADDR_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_HALT;
      pc_q        <= '0;
      ir_q        <= '0;
      bp_hit_q    <= 1'b0;
      halt_pend_q <= 1'b0;
      single_q    <= 1'b0;
    end else begin
      case (state_q)
        ST_HALT: begin
          if (ld_pc) pc_q <= ld_addr;
          if (halt_req) begin
            halt_pend_q <= 1'b0;
          end else if (step) begin
            state_q  <= ST_FETCH;
            single_q <= 1'b1;
            bp_hit_q <= 1'b0;
          end else if (run) begin
            state_q  <= ST_FETCH;
            single_q <= 1'b0;
            bp_hit_q <= 1'b0;
          end
        end
        ST_FETCH: begin
          if (halt_req) halt_pend_q <= 1'b1;
          if (MEM_LAT == 0) begin
            ir_q    <= mem_data;
            state_q <= ST_EXEC;
          end else begin
            state_q <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (halt_req) halt_pend_q <= 1'b1;
          ir_q    <= mem_data;
          state_q <= ST_EXEC;
        end
        ST_EXEC: begin
          pc_q <= pc_inc;
          // A pending halt is serviced by this EXEC, so it never outlives it.
          halt_pend_q <= 1'b0;
          if (halt_pend_q || halt_req) begin
            state_q <= ST_HALT;
          end else if (single_q) begin
            state_q <= ST_HALT;
          end else if (bp_en && (pc_inc == bp_addr)) begin
            state_q  <= ST_HALT;
            bp_hit_q <= 1'b1;
          end else if (!run) begin
            state_q <= ST_HALT;
          end else begin
            state_q <= ST_FETCH;
          end
        end
      endcase
    end
  end

  retire_counter #(
    .CNT_W (CNT_W)
  ) u_retire (
    .clk     (clk),
    .rst_n   (rst_n),
    .en_i    (commit),
    .count_o (retired)
  );

  assign commit   = (state_q == ST_EXEC);
  assign halted   = (state_q == ST_HALT);
  assign state    = state_q;
  assign mem_addr = pc_q;
  assign ir       = ir_q;
  assign bp_hit   = bp_hit_q;

endmodule

`default_nettype wire

// File: doc/exec_seq.md
# exec_seq

Multi-cycle execution sequencer for the 8-bit accumulator core. It replaces the free-running program counter with a run/step/halt state machine that owns the PC and fetches from a program memory of 0 or 1 cycle read latency. It latches the instruction word for the decoder and emits one `commit` pulse per instruction, which gates the datapath clock enables (`ce_reg`, `ce_a`, `ce_cy`). It also provides breakpoint, PC-load and retired-instruction-count debug features.

## Interface
- `ADDR_W`, 5: program address width; PC wraps modulo 2^ADDR_W.
- `INST_W`, 6: instruction word width.
- `CNT_W`, 16: retired-instruction counter width.
- `MEM_LAT`, 1: program memory read latency in cycles; legal values are 0 and 1 only.

Ports:
- `clk`  in  1  single clock; all state changes on its rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `run`  in  1  level; continuous execution while high.
- `step`  in  1  pulse; execute exactly one instruction from HALT.
- `halt_req`  in  1  pulse; stop after the current instruction.
- `bp_en`  in  1  breakpoint enable.
- `bp_addr`  in  ADDR_W  breakpoint address.
- `ld_pc`  in  1  pulse; load PC, honoured only in HALT.
- `ld_addr`  in  ADDR_W  PC load value.
- `mem_addr`  out  ADDR_W  program memory address; equals the registered PC.
- `mem_data`  in  INST_W  program memory read data.
- `ir`  out  INST_W  latched instruction, fed to the decoder.
- `commit`  out  1  high for exactly the EXEC cycle; ANDed with every datapath CE.
- `halted`  out  1  high in the HALT state.
- `bp_hit`  out  1  the last halt was caused by the breakpoint.
- `retired`  out  CNT_W  saturating count of committed instructions.
- `state`  out  2  current state encoding.

## Operation
- States and encodings: HALT=2'b00, FETCH=2'b01, WAIT=2'b10, EXEC=2'b11.
- Reset values: state=HALT, PC=0, `ir`=0, `commit`=0, `halted`=1, `bp_hit`=0, `retired`=0, `halt_pend`=0, `single`=0.
- HALT:
  - `ld_pc` sets PC=`ld_addr`.
  - `halt_req` is consumed here: it clears `halt_pend` and blocks leaving HALT in that cycle.
  - Otherwise `step` leads to FETCH with `single`=1. `step` wins over a simultaneous `run`.
  - Otherwise `run` leads to FETCH with `single`=0.
  - Leaving HALT clears `bp_hit`.
- FETCH: `mem_addr`=PC.
  - MEM_LAT=0: `ir`<=`mem_data`, then go to EXEC.
  - MEM_LAT=1: go to WAIT.
- WAIT: `ir`<=`mem_data`, then go to EXEC.
- EXEC:
  - `commit`=1.
  - PC<=PC+1; 2^ADDR_W−1 wraps to 0.
  - `retired`<=`retired`+1, saturating at all-ones.
- Next state after EXEC, in priority order:
  - `halt_pend`, or `halt_req` in this cycle: HALT.
  - `single`=1: HALT.
  - `bp_en` and PC+1==`bp_addr`: HALT, and set `bp_hit`=1.
  - `run`=0: HALT.
  - Otherwise: FETCH.
- `halt_req` seen in FETCH or WAIT sets the sticky `halt_pend`. The instruction in flight always completes; no partial instructions are committed.
- The breakpoint is compared against the next PC only. Resuming from a breakpoint therefore executes the instruction at `bp_addr` without re-triggering.
- `ld_pc` outside HALT is ignored.

## Timing
- Cycles per instruction: MEM_LAT=1 gives 3 (FETCH, WAIT, EXEC); MEM_LAT=0 gives 2 (FETCH, EXEC).
- `mem_addr` and `ir` are registered outputs.
- `commit` and `halted` are decoded combinationally from the state register only, with no input-to-output path.
- The datapath captures its result on the rising edge that ends the EXEC cycle. The PC advances on the same edge.
- From `step`/`run` sampled in HALT to the `commit` high cycle: 3 cycles (MEM_LAT=1) or 2 cycles (MEM_LAT=0).
- Asserting `rst_n` low at any time immediately forces all reset values, including `commit`=0 mid-EXEC, with no clock needed.

## Structure
- Package `exec_seq_pkg` holds:
  - the state enum with the encodings above;
  - default widths `ADDR_W`, `INST_W`, `CNT_W`.
- One sub-module, `retire_counter`: a CNT_W saturating incrementer with enable and asynchronous active-low reset.
- The FSM, PC, IR and breakpoint compare live in `exec_seq`.

## Test plan
1. Reset mid-EXEC during `run`: pull `rst_n` low. `commit`=0 immediately; PC=0, state=HALT, `halted`=1, `retired`=0.
2. MEM_LAT=1, word 6'h2A at address 0, `step` pulse. States go FETCH, WAIT, EXEC. `ir`=6'h2A; `commit` is high on the third cycle only; then PC=1, HALT, `retired`=1.
3. `run` held for 34 instructions. PC goes 31→0→2, `retired`=34, `commit` high every third cycle. Repeated with CNT_W=4: `retired` stays at 15.
4. `bp_en`=1, `bp_addr`=5, `run` from PC 0. Halts after 5 commits with PC=5 and `bp_hit`=1. Pulsing `run` again executes address 5, continues, and `bp_hit`=0.
5. `ld_pc` with `ld_addr`=20 in HALT gives PC=20. The same pulse during FETCH leaves PC unchanged.
6. `halt_req` during WAIT: the current instruction commits, then HALT. `halt_req` together with `run` in HALT: stays in HALT. MEM_LAT=0 `run`: `commit` every second cycle.
